gray_conv_arbiter: RTL and testbench

- Shares one binary-to-Gray conversion datapath among NREQ requesters using round-robin arbitration.
- Each requester presents a WIDTH-bit word through a valid/ready handshake.
- The block converts one accepted word at a time, holds the result in an output register, and tags it with the requester ID.
- It sits between the counter/pointer producers and any consumer that needs Gray-coded values, for example async-FIFO pointer sync logic.

---
 rtl/gray_conv_arbiter_if.sv | 26 ++
 rtl/gray_conv_arbiter.sv | 122 ++++++++++++
 tb/tb_gray_conv_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle between the requesters/consumer and gray_conv_arbiter.
// The master side is the requester/consumer. The slave side is the arbiter.
interface gray_conv_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;

  modport master (
    output req_valid, req_data, req_mode, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, req_mode, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary-to-Gray converter with a registered, ID-tagged result.
// Optional macro GRAY2BIN_EN adds per-request Gray-to-binary decoding selected by req_mode.
module gray_conv_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic clk,
  input  logic rst,
  gray_conv_arbiter_if.slave io_bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [IDW-1:0]   r_out_id;

  logic             w_found;
  logic [IDW-1:0]   w_grant_idx;
  int               w_scan;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_accept;
  logic             w_release;
  logic [IDW-1:0]   w_rr_next;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_conv;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_scan      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= NREQ) begin
        w_scan = w_scan - NREQ;
      end
      if (!w_found && io_bus.req_valid[w_scan]) begin
        w_found     = 1'b1;
        w_grant_idx = IDW'(w_scan);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_req_ready[w_grant_idx] = 1'b1;
          w_accept                 = 1'b1;
          w_state_next             = HOLD;
        end
      end
      HOLD: begin
        if (io_bus.out_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_rr_next  = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_sel_data = io_bus.req_data[w_grant_idx*WIDTH +: WIDTH];

  assign w_b2g[WIDTH-1] = w_sel_data[WIDTH-1];
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_b2g
    assign w_b2g[gi] = w_sel_data[gi+1] ^ w_sel_data[gi];
  end

`ifdef GRAY2BIN_EN
  logic [WIDTH-1:0] w_g2b;
  logic             w_sel_mode;
  // Each decoded bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
    assign w_g2b[gi] = ^(w_sel_data >> gi);
  end
  assign w_sel_mode = io_bus.req_mode[w_grant_idx];
  assign w_conv     = w_sel_mode ? w_g2b : w_b2g;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^io_bus.req_mode;
  assign w_conv        = w_b2g;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_out_data  <= w_conv;
        r_out_id    <= w_grant_idx;
        r_out_valid <= 1'b1;
        r_rr_ptr    <= w_rr_next;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Grant strobe must be quiet while reset is asserted, even in the same cycle.
  assign io_bus.req_ready = rst ? '0 : w_req_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_id    = r_out_id;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed table-driven bench for gray_conv_arbiter (NREQ=4, WIDTH=4, IDW=2).
module tb_gray_conv_arbiter;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [3:0]  mode;
    logic        ordy;
    logic [3:0]  e_ready;
    logic        e_ov;
    logic [3:0]  e_od;
    logic [1:0]  e_id;
  } vec_t;

`ifdef GRAY2BIN_EN
  localparam logic [3:0] MODE_EXP = 4'b1011;
`else
  localparam logic [3:0] MODE_EXP = 4'b1001;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];

  gray_conv_arbiter_if #(.NREQ(4), .WIDTH(4), .IDW(2)) bus ();

  gray_conv_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [15:0] d, input logic [3:0] m, input logic o,
                     input logic [3:0] er, input logic eov, input logic [3:0] eod, input logic [1:0] eid);
    vec_t t;
    t.valid = v; t.data = d; t.mode = m; t.ordy = o;
    t.e_ready = er; t.e_ov = eov; t.e_od = eod; t.e_id = eid;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic [3:0] m, input logic o);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_mode  = m;
    bus.out_ready = o;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(4'b0000, 16'h0000, 4'b0000, 1'b0);

    // Round-robin from reset: d0..d3 = 0111,1000,0000,1111
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd0);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0100, 2'd0);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1100, 2'd1);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b1100, 2'd1);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b1000, 1'b0, 4'b0000, 2'd2);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1000, 2'd3);
    add(4'b1111, 16'hF087, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b1000, 2'd3);
    add(4'b0000, 16'hF087, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd0);
    // Single request on requester 2 (1011 -> 1110), then 5 cycles of backpressure
    add(4'b0100, 16'h0B00, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0100, 2'd0);
    for (int i = 0; i < 5; i++) begin
      add(4'b0001, 16'h0B06, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1110, 2'd2);
    end
    add(4'b0001, 16'h0B06, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1110, 2'd2);
    add(4'b0001, 16'h0B06, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b1110, 2'd2);
    add(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0101, 2'd0);
    add(4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0101, 2'd0);
    // Wrap: grant 2 puts rr_ptr at 3, then requesters 1 and 3 compete
    add(4'b0100, 16'h0300, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0101, 2'd0);
    add(4'b1010, 16'hC020, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0010, 2'd2);
    add(4'b1010, 16'hC020, 4'b0000, 1'b1, 4'b1000, 1'b0, 4'b0010, 2'd2);
    add(4'b0010, 16'hC020, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1010, 2'd3);
    add(4'b0010, 16'hC020, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b1010, 2'd3);
    add(4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0011, 2'd1);
    // Mode bit on requester 1 with data 1110
    add(4'b0010, 16'h00E0, 4'b0010, 1'b1, 4'b0010, 1'b0, 4'b0011, 2'd1);
    add(4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 1'b1, MODE_EXP, 2'd1);
    add(4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 1'b0, MODE_EXP, 2'd1);

    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ready", -1, 32'(bus.req_ready), 32'h0);
    chk("rst_out_valid", -1, 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", -1, 32'(bus.out_data), 32'h0);
    chk("rst_out_id", -1, 32'(bus.out_id), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].valid, tbl[i].data, tbl[i].mode, tbl[i].ordy);
      #1;
      $display("step %0d: valid=%b ready=%b out_valid=%b out_data=%b out_id=%0d",
               i, tbl[i].valid, bus.req_ready, bus.out_valid, bus.out_data, bus.out_id);
      chk("req_ready", i, 32'(bus.req_ready), 32'(tbl[i].e_ready));
      chk("out_valid", i, 32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk("out_data", i, 32'(bus.out_data), 32'(tbl[i].e_od));
      chk("out_id", i, 32'(bus.out_id), 32'(tbl[i].e_id));
      @(negedge clk);
    end

    // Async reset while holding a result; rr_ptr must restart at requester 0.
    drive(4'b0100, 16'h0B00, 4'b0000, 1'b0);
    #1;
    chk("hold_grant", 100, 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    drive(4'b1111, 16'h0B0D, 4'b0000, 1'b0);
    #1;
    chk("hold_out_valid", 101, 32'(bus.out_valid), 32'h1);
    chk("hold_out_data", 101, 32'(bus.out_data), 32'hE);
    $display("step 101: held out_data=%b out_id=%0d before reset", bus.out_data, bus.out_id);
    #1;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 102, 32'(bus.out_valid), 32'h0);
    chk("async_out_data", 102, 32'(bus.out_data), 32'h0);
    chk("async_out_id", 102, 32'(bus.out_id), 32'h0);
    chk("async_ready", 102, 32'(bus.req_ready), 32'h0);
    $display("step 102: reset asserted, out_valid=%b out_data=%b", bus.out_valid, bus.out_data);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 103, 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    #1;
    chk("post_rst_out_data", 104, 32'(bus.out_data), 32'hB);
    chk("post_rst_out_id", 104, 32'(bus.out_id), 32'h0);
    $display("step 104: first grant after reset out_data=%b out_id=%0d", bus.out_data, bus.out_id);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
